// File: rtl/bram_bank_loader.sv
// Banked BRAM loader: scatters a byte-serial stream round-robin over BANK_CNT banks,
// then serves registered read-valid. Optional macro: BRAM_LOADER_RD_GUARD_EN (reads only in DONE).
module bram_bank_loader #(
  parameter int BRAM_ADDR_WIDTH = 10,
  parameter int BANK_DATA_WIDTH = 8,
  parameter int BANK_CNT        = 4,
  parameter int WORD_CNT        = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [BANK_DATA_WIDTH-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_wr_addr,
  output logic [BANK_CNT-1:0]        bram_wr_en,
  output logic [BANK_DATA_WIDTH-1:0] bram_din,
  input  logic                       rd_req,
  input  logic [BRAM_ADDR_WIDTH-1:0] rd_addr,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_rd_addr,
  output logic                       rd_valid,
  output logic                       busy,
  output logic                       done,
  output logic [BRAM_ADDR_WIDTH:0]   words_loaded,
  output logic [1:0]                 dbg_state
);

  localparam int BANK_IDX_W = (BANK_CNT > 1) ? $clog2(BANK_CNT) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [BANK_IDX_W-1:0]    LAST_BANK = BANK_IDX_W'(BANK_CNT - 1);
  localparam logic [BRAM_ADDR_WIDTH:0] LAST_WORD = (BRAM_ADDR_WIDTH + 1)'(WORD_CNT - 1);
  localparam logic [BANK_CNT-1:0]      ONE_HOT0  = BANK_CNT'(1);

  logic [1:0]                 state_q, state_d;
  logic [BANK_IDX_W-1:0]      bank_idx_q, bank_idx_d;
  logic [BRAM_ADDR_WIDTH-1:0] word_addr_q, word_addr_d;
  logic [BRAM_ADDR_WIDTH:0]   words_loaded_q, words_loaded_d;
  logic [BRAM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [BANK_CNT-1:0]        wr_en_q, wr_en_d;
  logic [BANK_DATA_WIDTH-1:0] din_q, din_d;
  logic                       rd_valid_q, rd_valid_d;

  logic xfer;
  logic rd_accept;

  // Input handshake: an element moves on a rising edge where in_valid and in_ready
  // are both high; in_ready depends only on the state, never on in_valid.
  assign in_ready = (state_q == ST_LOAD);
  assign xfer     = in_valid & in_ready;

`ifdef BRAM_LOADER_RD_GUARD_EN
  assign rd_accept = rd_req & (state_q == ST_DONE);
`else
  assign rd_accept = rd_req;
`endif

  always_comb begin
    state_d        = state_q;
    bank_idx_d     = bank_idx_q;
    word_addr_d    = word_addr_q;
    words_loaded_d = words_loaded_q;
    wr_addr_d      = wr_addr_q;
    din_d          = din_q;
    wr_en_d        = '0;
    rd_valid_d     = rd_accept;

    if (start && (state_q != ST_LOAD)) begin
      state_d        = ST_LOAD;
      bank_idx_d     = '0;
      word_addr_d    = '0;
      words_loaded_d = '0;
    end else if (xfer) begin
      din_d     = in_data;
      wr_addr_d = word_addr_q;
      wr_en_d   = ONE_HOT0 << bank_idx_q;
      if (bank_idx_q == LAST_BANK) begin
        bank_idx_d     = '0;
        word_addr_d    = word_addr_q + 1'b1;
        words_loaded_d = words_loaded_q + 1'b1;
        // The element closing the last word finishes the load on this same edge.
        if (words_loaded_q == LAST_WORD) begin
          state_d = ST_DONE;
        end
      end else begin
        bank_idx_d = bank_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      bank_idx_q     <= '0;
      word_addr_q    <= '0;
      words_loaded_q <= '0;
      wr_addr_q      <= '0;
      wr_en_q        <= '0;
      din_q          <= '0;
      rd_valid_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      bank_idx_q     <= bank_idx_d;
      word_addr_q    <= word_addr_d;
      words_loaded_q <= words_loaded_d;
      wr_addr_q      <= wr_addr_d;
      wr_en_q        <= wr_en_d;
      din_q          <= din_d;
      rd_valid_q     <= rd_valid_d;
    end
  end

  assign bram_wr_addr = wr_addr_q;
  assign bram_wr_en   = wr_en_q;
  assign bram_din     = din_q;
  assign bram_rd_addr = rd_addr;
  assign rd_valid     = rd_valid_q;
  assign busy         = (state_q == ST_LOAD);
  assign done         = (state_q == ST_DONE);
  assign words_loaded = words_loaded_q;
  assign dbg_state    = state_q;

endmodule
